// File: rtl/btn_pkg.sv
// Shared types for the push-button input conditioner: debounce FSM states and
// a counter-width helper used when sizing CNT_W for a given timing.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser; RST_VAL sets the flops' reset level so
// the output matches the idle level of the pin being synchronised.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops to settle metastability from the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, normalise to active-high pressed,
// debounce with a stability counter and emit press/release/long-press pulses.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic             L_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] L_DEB     = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] L_LONG    = CNT_W'(LONG_CYCLES);
  localparam logic             L_LONG_EN = (LONG_CYCLES != 0) ? 1'b1 : 1'b0;

  logic             w_sync;
  logic             w_s;
  logic [CNT_W-1:0] w_hold_inc;

  btn_state_e       r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [CNT_W-1:0] r_hold,      w_hold_nxt;
  logic             r_long_done, w_long_done_nxt;
  logic             r_level,     w_level_nxt;
  logic             r_press,     w_press_nxt;
  logic             r_release,   w_release_nxt;
  logic             r_long,      w_long_nxt;

  // Flops reset to the released pin level so reset release never looks like a press.
  sync_2ff #(
    .RST_VAL (L_IDLE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (btn_raw),
    .o_q     (w_sync)
  );

  assign w_s        = w_sync ^ L_IDLE;
  assign w_hold_inc = (r_hold == L_LONG) ? r_hold : (r_hold + CNT_W'(1));

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RELEASED;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_long_done <= w_long_done_nxt;
      r_level     <= w_level_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  // Next-state logic; the hold counter keeps running through RELEASE_WAIT so a
  // bounce on release neither restarts nor repeats the long-press event.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_long_done_nxt = r_long_done;
    w_level_nxt     = r_level;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;

    if ((r_state == PRESSED) || (r_state == RELEASE_WAIT)) begin
      w_hold_nxt = w_hold_inc;
      if (L_LONG_EN && (w_hold_inc == L_LONG) && !r_long_done) begin
        w_long_nxt      = 1'b1;
        w_long_done_nxt = 1'b1;
      end else begin
        w_long_nxt      = 1'b0;
      end
    end else begin
      w_hold_nxt = r_hold;
    end

    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_DEB) begin
          w_state_nxt     = PRESSED;
          w_cnt_nxt       = '0;
          w_level_nxt     = 1'b1;
          w_press_nxt     = 1'b1;
          w_hold_nxt      = '0;
          w_long_done_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == L_DEB) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;

endmodule
